converter_f2i: RTL and testbench

//  IEEE-754 single-precision float to 32-bit two's-complement integer converter.

---
 rtl/converter_f2i.sv | 158 +++++++++++++++
 tb/tb_converter_f2i.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/converter_f2i.sv
// Float-to-integer converter: takes an IEEE-754 single-precision operand and
// returns the 32-bit two's-complement integer, truncated toward zero.
// Out-of-range inputs saturate (SAT_EN=1) or return 0x80000000 (SAT_EN=0).
// STB/ACK handshake on both sides; one operand in flight at a time.
//
// state    | meaning
// GET_A    | idle, offer o_A_ACK and wait for an operand
// UNPACK   | split the operand into sign, unbiased exponent, mantissa
// CLASSIFY | zero/small -> 0, Inf/NaN/too large -> saturate, else shift
// SHIFT    | align the mantissa right one bit per clock until e reaches 31
// SIGN     | apply the sign (two's-complement negate)
// PUT_Z    | present o_Z with o_Z_STB until the consumer acks
module converter_f2i #(
  parameter bit SAT_EN = 1'b1
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [31:0] i_A,
  input  logic        i_A_STB,
  output logic        o_A_ACK,
  output logic [31:0] o_Z,
  output logic        o_Z_STB,
  input  logic        i_Z_ACK
);

  typedef enum logic [2:0] {
    GET_A    = 3'd0,
    UNPACK   = 3'd1,
    CLASSIFY = 3'd2,
    SHIFT    = 3'd3,
    SIGN     = 3'd4,
    PUT_Z    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic        [31:0] a_q, a_d;
  logic               s_q, s_d;
  logic signed [8:0]  e_q, e_d;
  logic        [31:0] m_q, m_d;
  logic        [31:0] r_q, r_d;
  logic        [31:0] z_q, z_d;
  logic               a_ack_q, a_ack_d;
  logic               z_stb_q, z_stb_d;

  logic               exp_zero;
  logic               exp_ones;
  logic               is_nan;
  logic        [31:0] sat_val;

  // Operand classification and the saturation value for this operand.
  // NaN never picks the positive limit, whatever its sign bit says.
  always_comb begin
    exp_zero = (a_q[30:23] == 8'h00);
    exp_ones = (a_q[30:23] == 8'hFF);
    is_nan   = exp_ones && (a_q[22:0] != 23'd0);
    if (!SAT_EN || is_nan || s_q) begin
      sat_val = 32'h8000_0000;
    end else begin
      sat_val = 32'h7FFF_FFFF;
    end
  end

  // Next-state and datapath logic; handshake flags default low so they are
  // only ever high in their own state.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    s_d     = s_q;
    e_d     = e_q;
    m_d     = m_q;
    r_d     = r_q;
    z_d     = z_q;
    a_ack_d = 1'b0;
    z_stb_d = 1'b0;
    unique case (state_q)
      GET_A: begin
        a_ack_d = 1'b1;
        if (a_ack_q && i_A_STB) begin
          a_d     = i_A;
          a_ack_d = 1'b0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        s_d     = a_q[31];
        e_d     = $signed({1'b0, a_q[30:23]}) - 9'sd127;
        m_d     = {1'b1, a_q[22:0], 8'h00};
        state_d = CLASSIFY;
      end
      CLASSIFY: begin
        if (exp_zero || (e_q < 9'sd0)) begin
          r_d     = 32'd0;
          state_d = SIGN;
        end else if (exp_ones || (e_q > 9'sd30)) begin
          // Also covers exactly -2^31, whose correct result is the limit.
          r_d     = sat_val;
          state_d = PUT_Z;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (e_q < 9'sd31) begin
          m_d = m_q >> 1;
          e_d = e_q + 9'sd1;
        end else begin
          r_d     = m_q;
          state_d = SIGN;
        end
      end
      SIGN: begin
        r_d     = s_q ? (~r_q + 32'd1) : r_q;
        state_d = PUT_Z;
      end
      PUT_Z: begin
        z_stb_d = 1'b1;
        z_d     = r_q;
        if (z_stb_q && i_Z_ACK) begin
          z_stb_d = 1'b0;
          state_d = GET_A;
        end
      end
      default: begin
        state_d = GET_A;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= GET_A;
      a_q     <= 32'd0;
      s_q     <= 1'b0;
      e_q     <= 9'sd0;
      m_q     <= 32'd0;
      r_q     <= 32'd0;
      z_q     <= 32'd0;
      a_ack_q <= 1'b0;
      z_stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      s_q     <= s_d;
      e_q     <= e_d;
      m_q     <= m_d;
      r_q     <= r_d;
      z_q     <= z_d;
      a_ack_q <= a_ack_d;
      z_stb_q <= z_stb_d;
    end
  end

  assign o_A_ACK = a_ack_q;
  assign o_Z     = z_q;
  assign o_Z_STB = z_stb_q;

endmodule

// File: tb/tb_converter_f2i.sv
// Bench for converter_f2i: directed vectors plus a throttled random stream.
// Stimulus pushes expected results into a scoreboard queue; a monitor pops
// and compares whenever an output transfer happens.
module tb_converter_f2i;

  logic        i_CLK = 1'b0;
  logic        i_RST = 1'b1;
  logic [31:0] i_A = 32'd0;
  logic        i_A_STB = 1'b0;
  logic        o_A_ACK;
  logic [31:0] o_Z;
  logic        o_Z_STB;
  logic        i_Z_ACK = 1'b1;

  logic [31:0] a0 = 32'd0;
  logic        a0_stb = 1'b0;
  logic        a0_ack;
  logic [31:0] z0;
  logic        z0_stb;
  logic        z0_ack = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cyc = 0;
  int ack_mode = 0;   // 0: always ack, 1: random ack, 2: driven by stimulus

  typedef struct {
    logic [31:0] a;
    logic [31:0] z;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  converter_f2i #(.SAT_EN(1'b1)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_A(i_A), .i_A_STB(i_A_STB), .o_A_ACK(o_A_ACK),
    .o_Z(o_Z), .o_Z_STB(o_Z_STB), .i_Z_ACK(i_Z_ACK)
  );

  converter_f2i #(.SAT_EN(1'b0)) dut0 (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_A(a0), .i_A_STB(a0_stb), .o_A_ACK(a0_ack),
    .o_Z(z0), .o_Z_STB(z0_stb), .i_Z_ACK(z0_ack)
  );

  always #5 i_CLK = ~i_CLK;

  always @(posedge i_CLK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: truncating float->int with saturation (SAT_EN=1 flavour).
  function automatic logic [31:0] model(input logic [31:0] f);
    int          ex;
    logic [63:0] mag;
    logic [31:0] r;
    ex = int'(f[30:23]) - 127;
    if (f[30:23] == 8'hFF) begin
      if (f[22:0] != 23'd0) return 32'h8000_0000;
      return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    if (f[30:23] == 8'h00 || ex < 0) return 32'd0;
    if (ex > 30) return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    mag = {40'd0, 1'b1, f[22:0]};
    if (ex >= 23) mag = mag << (ex - 23);
    else mag = mag >> (23 - ex);
    r = mag[31:0];
    return f[31] ? (~r + 32'd1) : r;
  endfunction

  // Ack driver for the modes that are not hand-driven.
  always @(posedge i_CLK) begin
    #1;
    if (ack_mode == 0) i_Z_ACK = 1'b1;
    else if (ack_mode == 1) i_Z_ACK = ($urandom_range(0, 1) == 1);
  end

  logic        stb_prev = 1'b0;
  logic [31:0] z_prev = 32'd0;

  // Monitor: latency capture, hold stability, and scoreboard compare.
  always @(negedge i_CLK) begin
    exp_t ent;
    if (i_RST) begin
      stb_prev = 1'b0;
    end else begin
      if (o_Z_STB && !stb_prev) rise_cyc = cyc;
      if (o_Z_STB && stb_prev) check("z_stable", o_Z, z_prev);
      if (o_Z_STB && i_Z_ACK) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%08h, expected no output", o_Z);
        end else begin
          ent = sb.pop_front();
          check($sformatf("result(a=%08h)", ent.a), o_Z, ent.z);
          if (ent.lat >= 0)
            check($sformatf("latency(a=%08h)", ent.a), 32'(rise_cyc - ent.acc), 32'(ent.lat));
        end
      end
      stb_prev = o_Z_STB;
      z_prev   = o_Z;
    end
  end

  // Offer one operand, wait for acceptance, optionally log the expectation.
  task automatic send(input logic [31:0] val, input logic [31:0] z_exp, input int lat, input bit push);
    exp_t ent;
    bit   got;
    @(posedge i_CLK); #1;
    i_A     = val;
    i_A_STB = 1'b1;
    got = 1'b0;
    for (int g = 0; g < 400 && !got; g++) begin
      @(negedge i_CLK);
      if (o_A_ACK && i_A_STB) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got no o_A_ACK, expected accept of 0x%08h", val);
    end else if (push) begin
      ent.a   = val;
      ent.z   = z_exp;
      ent.lat = lat;
      ent.acc = cyc + 1;
      sb.push_back(ent);
    end
    @(posedge i_CLK); #1;
    i_A_STB = 1'b0;
  endtask

  task automatic drain();
    for (int g = 0; g < 1000 && sb.size() != 0; g++) @(negedge i_CLK);
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic send0(input logic [31:0] val, input logic [31:0] z_exp);
    bit got;
    @(posedge i_CLK); #1;
    a0     = val;
    a0_stb = 1'b1;
    got = 1'b0;
    for (int g = 0; g < 100 && !got; g++) begin
      @(negedge i_CLK);
      if (a0_ack && a0_stb) got = 1'b1;
    end
    @(posedge i_CLK); #1;
    a0_stb = 1'b0;
    got = 1'b0;
    for (int g = 0; g < 100 && !got; g++) begin
      @(negedge i_CLK);
      if (z0_stb) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL sat0_timeout: got no o_Z_STB, expected result for 0x%08h", val);
    end else begin
      check($sformatf("sat0(a=%08h)", val), z0, z_exp);
    end
  endtask

  initial begin
    logic [31:0] f;
    bit          got;

    // Reset values, and o_A_ACK rising one cycle after reset release.
    repeat (3) @(posedge i_CLK);
    @(negedge i_CLK);
    check("rst_a_ack", 32'(o_A_ACK), 32'd0);
    check("rst_z_stb", 32'(o_Z_STB), 32'd0);
    check("rst_z", o_Z, 32'd0);
    @(posedge i_CLK); #1;
    i_RST = 1'b0;
    @(negedge i_CLK);
    check("a_ack_before_rise", 32'(o_A_ACK), 32'd0);
    @(negedge i_CLK);
    check("a_ack_rise", 32'(o_A_ACK), 32'd1);

    // In-range values and their latency.
    send(32'h3F80_0000, 32'h0000_0001, 36, 1'b1);
    send(32'h47F1_2000, 32'h0001_E240, 20, 1'b1);
    send(32'h4EFF_FFFF, 32'h7FFF_FF80, 6, 1'b1);
    // Negative, small and zero-like values.
    send(32'hC020_0000, 32'hFFFF_FFFE, 35, 1'b1);
    send(32'h3F00_0000, 32'h0000_0000, 4, 1'b1);
    send(32'h8000_0000, 32'h0000_0000, 4, 1'b1);
    send(32'h0000_0001, 32'h0000_0000, 4, 1'b1);
    send(32'hBF7F_FFFF, 32'h0000_0000, 4, 1'b1);
    // Saturation path.
    send(32'h4F00_0000, 32'h7FFF_FFFF, 3, 1'b1);
    send(32'hCF00_0000, 32'h8000_0000, 3, 1'b1);
    send(32'h7F80_0000, 32'h7FFF_FFFF, 3, 1'b1);
    send(32'hFF80_0000, 32'h8000_0000, 3, 1'b1);
    send(32'h7FC0_0000, 32'h8000_0000, 3, 1'b1);
    send(32'hFFC0_0000, 32'h8000_0000, 3, 1'b1);
    drain();

    // Back-pressure: hold off the ack for 20 cycles, then a one-cycle ack.
    ack_mode = 2;
    @(posedge i_CLK); #1;
    i_Z_ACK = 1'b0;
    send(32'h3F80_0000, 32'h0000_0001, 36, 1'b1);
    got = 1'b0;
    for (int g = 0; g < 100 && !got; g++) begin
      @(negedge i_CLK);
      if (o_Z_STB) got = 1'b1;
    end
    check("hold_stb_seen", 32'(got), 32'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge i_CLK);
      check("hold_z_stb", 32'(o_Z_STB), 32'd1);
      check("hold_z", o_Z, 32'h0000_0001);
      check("hold_a_ack", 32'(o_A_ACK), 32'd0);
    end
    @(posedge i_CLK); #1;
    i_Z_ACK = 1'b1;
    @(posedge i_CLK); #1;
    i_Z_ACK = 1'b0;
    @(negedge i_CLK);
    check("ack_z_stb_drop", 32'(o_Z_STB), 32'd0);
    check("ack_a_ack_still_low", 32'(o_A_ACK), 32'd0);
    @(negedge i_CLK);
    check("ack_a_ack_rise", 32'(o_A_ACK), 32'd1);
    check("ack_queue_empty", 32'(sb.size()), 32'd0);
    ack_mode = 0;

    // Reset during SHIFT abandons the operand; next operand is clean.
    send(32'h3F80_0000, 32'h0000_0001, -1, 1'b0);
    repeat (10) @(posedge i_CLK);
    #1;
    i_RST = 1'b1;
    @(posedge i_CLK); #1;
    i_RST = 1'b0;
    @(negedge i_CLK);
    check("midrst_z_stb", 32'(o_Z_STB), 32'd0);
    check("midrst_a_ack", 32'(o_A_ACK), 32'd0);
    check("midrst_z", o_Z, 32'd0);
    send(32'h4000_0000, 32'h0000_0002, 35, 1'b1);
    drain();

    // Random throttled stream.
    ack_mode = 1;
    for (int n = 0; n < 100; n++) begin
      int sel;
      logic [7:0] ex;
      sel = $urandom_range(0, 19);
      if (sel == 0) ex = 8'h00;
      else if (sel == 1) ex = 8'hFF;
      else ex = 8'($urandom_range(112, 160));
      f = {1'($urandom_range(0, 1)), ex, 23'($urandom)};
      repeat ($urandom_range(0, 2)) @(posedge i_CLK);
      send(f, model(f), -1, 1'b1);
    end
    drain();
    ack_mode = 0;

    // Non-saturating variant: every out-of-range case gives 0x80000000.
    send0(32'h4F00_0000, 32'h8000_0000);
    send0(32'h7F80_0000, 32'h8000_0000);
    send0(32'hCF00_0000, 32'h8000_0000);
    send0(32'h3FC0_0000, 32'h0000_0001);

    repeat (5) @(posedge i_CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
